// File: rtl/rom_streamer.sv
// Streams a burst of words from a synchronous ROM (1-cycle read latency) through
// a 3-entry output FIFO with valid/ready handshake.
module rom_streamer #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic [ADDR_WIDTH-1:0] start_addr,
    input  logic [ADDR_WIDTH:0]   len,
    output logic [ADDR_WIDTH-1:0] rom_addr,
    input  logic [DATA_WIDTH-1:0] rom_data,
    output logic                  m_valid,
    input  logic                  m_ready,
    output logic [DATA_WIDTH-1:0] m_data,
    output logic                  busy,
    output logic                  done
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_DRAIN,
        S_DONE
    } state_t;

    state_t                r_state;
    logic [ADDR_WIDTH-1:0] r_addr;
    logic [ADDR_WIDTH:0]   r_remain;
    logic                  r_inflight;
    logic                  r_busy;
    logic                  r_done;

    logic [DATA_WIDTH-1:0] r_fifo [0:2];
    logic [1:0]            r_wr_ptr;
    logic [1:0]            r_rd_ptr;
    logic [1:0]            r_count;

    logic                  w_issue;
    logic                  w_push;
    logic                  w_pop;

    // Issue only when every outstanding word is guaranteed a FIFO slot.
    assign w_issue = (r_state == S_RUN) && ((3'(r_count) + 3'(r_inflight)) <= 3'd2);
    assign w_push  = r_inflight;
    assign w_pop   = (r_count != 2'd0) && m_ready;

    assign rom_addr = r_addr;
    assign m_valid  = (r_count != 2'd0);
    assign m_data   = r_fifo[r_rd_ptr];
    assign busy     = r_busy;
    assign done     = r_done;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= S_IDLE;
            r_addr     <= '0;
            r_remain   <= '0;
            r_inflight <= 1'b0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
        end else begin
            r_inflight <= w_issue;
            case (r_state)
                S_IDLE: begin
                    if (start && (len != '0)) begin
                        r_state  <= S_RUN;
                        r_addr   <= start_addr;
                        r_remain <= len;
                        r_busy   <= 1'b1;
                    end
                end
                S_RUN: begin
                    if (w_issue) begin
                        r_addr   <= r_addr + ADDR_WIDTH'(1);
                        r_remain <= r_remain - (ADDR_WIDTH + 1)'(1);
                        if (r_remain == (ADDR_WIDTH + 1)'(1)) begin
                            r_state <= S_DRAIN;
                        end
                    end
                end
                S_DRAIN: begin
                    if ((r_count == 2'd0) && !r_inflight) begin
                        r_state <= S_DONE;
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                    end
                end
                S_DONE: begin
                    r_state <= S_IDLE;
                    r_done  <= 1'b0;
                end
                default: begin
                    r_state <= S_IDLE;
                    r_busy  <= 1'b0;
                    r_done  <= 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < 3; i++) begin
                r_fifo[i] <= '0;
            end
            r_wr_ptr <= 2'd0;
            r_rd_ptr <= 2'd0;
            r_count  <= 2'd0;
        end else begin
            if (w_push) begin
                r_fifo[r_wr_ptr] <= rom_data;
                r_wr_ptr         <= (r_wr_ptr == 2'd2) ? 2'd0 : r_wr_ptr + 2'd1;
            end
            if (w_pop) begin
                r_rd_ptr <= (r_rd_ptr == 2'd2) ? 2'd0 : r_rd_ptr + 2'd1;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 2'd1;
                2'b01:   r_count <= r_count - 2'd1;
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

// File: tb/tb_rom_streamer.sv
// Bench for rom_streamer: expected-word queue built from ROM contents at burst
// acceptance, checked on every handshake, plus directed literal checks.
module tb_rom_streamer;

    localparam int DW = 8;
    localparam int AW = 4;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          start = 1'b0;
    logic [AW-1:0] start_addr = '0;
    logic [AW:0]   len = '0;
    logic [AW-1:0] rom_addr;
    logic [DW-1:0] rom_data = '0;
    logic          m_valid;
    logic          m_ready = 1'b0;
    logic [DW-1:0] m_data;
    logic          busy;
    logic          done;

    logic [DW-1:0] rom [16];
    logic [DW-1:0] exp_q [$];
    int            total = 0;
    int            bad = 0;

    logic          pv = 1'b0;
    logic          pr = 1'b0;
    logic          prst = 1'b0;
    logic [DW-1:0] pd = '0;

    rom_streamer #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .start_addr (start_addr),
        .len        (len),
        .rom_addr   (rom_addr),
        .rom_data   (rom_data),
        .m_valid    (m_valid),
        .m_ready    (m_ready),
        .m_data     (m_data),
        .busy       (busy),
        .done       (done)
    );

    always #5 clk = ~clk;

    always @(posedge clk) rom_data <= rom[rom_addr];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Drive start for one cycle from IDLE; a non-zero length queues the words it must yield.
    task automatic start_burst(input int sa, input int ln);
        start_addr = AW'(sa);
        len        = (AW + 1)'(ln);
        start      = 1'b1;
        for (int k = 0; k < ln; k++) exp_q.push_back(rom[(sa + k) % 16]);
        step(1);
        start = 1'b0;
    endtask

    task automatic wait_done();
        int n = 0;
        while (!done && n < 200) begin
            step(1);
            n++;
        end
        chk("done_seen", 32'(done), 32'd1);
        chk("busy_at_done", 32'(busy), 32'd0);
        chk("queue_drained", 32'(exp_q.size()), 32'd0);
        step(1);
        chk("done_pulse_width", 32'(done), 32'd0);
    endtask

    initial begin
        forever begin
            @(negedge clk);
            if (rst_n && prst && pv && !pr) begin
                chk("hold_valid", 32'(m_valid), 32'd1);
                chk("hold_data", 32'(m_data), 32'(pd));
            end
            if (rst_n && m_valid && m_ready) begin
                if (exp_q.size() == 0) chk("word_expected", 32'(exp_q.size()), 32'd1);
                else chk("stream_data", 32'(m_data), 32'(exp_q.pop_front()));
            end
            pv   = m_valid;
            pr   = m_ready;
            pd   = m_data;
            prst = rst_n;
        end
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        int ph;
        int n;
        for (int i = 0; i < 16; i++) rom[i] = 8'(i * 3);
        m_ready = 1'b1;
        step(1);
        chk("rst_m_valid", 32'(m_valid), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_rom_addr", 32'(rom_addr), 32'd0);
        chk("rst_m_data", 32'(m_data), 32'd0);

        // Full 16-word burst, consumer always ready.
        rst_n = 1'b1;
        start_burst(0, 16);
        chk("t1_busy_c1", 32'(busy), 32'd1);
        chk("t1_valid_c1", 32'(m_valid), 32'd0);
        step(1);
        chk("t1_valid_c2", 32'(m_valid), 32'd0);
        step(1);
        chk("t1_first_valid", 32'(m_valid), 32'd1);
        chk("t1_first_word", 32'(m_data), 32'h00);
        step(15);
        chk("t1_last_valid", 32'(m_valid), 32'd1);
        chk("t1_last_word", 32'(m_data), 32'h2D);
        step(1);
        chk("t1_drain_busy", 32'(busy), 32'd1);
        chk("t1_drain_done", 32'(done), 32'd0);
        chk("t1_drain_valid", 32'(m_valid), 32'd0);
        step(1);
        chk("t1_done", 32'(done), 32'd1);
        chk("t1_busy_low", 32'(busy), 32'd0);
        chk("t1_queue", 32'(exp_q.size()), 32'd0);
        step(1);
        chk("t1_done_low", 32'(done), 32'd0);

        // Address wrap 14,15,0,1.
        step(1);
        start_burst(14, 4);
        step(2);
        chk("t2_wrap_first", 32'(m_data), 32'd42);
        wait_done();

        // Backpressure pattern 1,0,0,1.
        step(1);
        start_burst(3, 8);
        ph = 0;
        n  = 0;
        while (!done && n < 300) begin
            m_ready = ((ph % 4) == 0) || ((ph % 4) == 3);
            step(1);
            ph++;
            n++;
        end
        m_ready = 1'b1;
        chk("t3_done_seen", 32'(done), 32'd1);
        chk("t3_queue", 32'(exp_q.size()), 32'd0);
        step(1);

        // Consumer stalled for 10 cycles: reads must stop at FIFO capacity.
        m_ready = 1'b0;
        start_burst(5, 5);
        step(9);
        chk("t4_reads_issued", 32'(rom_addr), 32'd8);
        chk("t4_valid", 32'(m_valid), 32'd1);
        chk("t4_head", 32'(m_data), 32'd15);
        m_ready = 1'b1;
        wait_done();

        // len=0 ignored; start during RUN ignored.
        start_burst(0, 0);
        for (int i = 0; i < 3; i++) begin
            chk("t5_len0_idle", {29'd0, busy, done, m_valid}, 32'd0);
            step(1);
        end
        start_burst(2, 3);
        step(1);
        start_addr = AW'(0);
        len        = (AW + 1)'(9);
        start      = 1'b1;
        step(1);
        start = 1'b0;
        wait_done();
        step(5);
        chk("t5_no_second_burst", 32'(busy), 32'd0);

        // Reset after two words of an 8-word burst.
        start_burst(0, 8);
        step(4);
        rst_n = 1'b0;
        exp_q.delete();
        #1;
        chk("t6_rst_valid", 32'(m_valid), 32'd0);
        chk("t6_rst_busy", 32'(busy), 32'd0);
        chk("t6_rst_done", 32'(done), 32'd0);
        chk("t6_rst_addr", 32'(rom_addr), 32'd0);
        chk("t6_rst_data", 32'(m_data), 32'd0);
        step(1);
        rst_n = 1'b1;
        for (int i = 0; i < 6; i++) begin
            step(1);
            chk("t6_no_residual", {30'd0, m_valid, busy}, 32'd0);
        end

        // Start accepted on the very first edge after reset release.
        rst_n = 1'b0;
        step(1);
        rst_n = 1'b1;
        start_burst(9, 2);
        chk("t7_busy", 32'(busy), 32'd1);
        step(2);
        chk("t7_valid", 32'(m_valid), 32'd1);
        chk("t7_first_word", 32'(m_data), 32'd27);
        wait_done();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
